rx_channel: RTL and testbench
=============================

# rx_channel

Receive-side stage of a single AXI channel: it sits directly downstream of the transmit stage on the same bus, accepting VALID/xDATA beats and driving READY back. Accepted beats are buffered in a DEPTH-entry first-word-fall-through FIFO and presented to a local consumer through an rx_valid/rx_ready handshake. READY is the registered not-full condition, so the transmit side never sees a combinational path from the consumer. An optional protocol checker flags transmitter-side handshake violations.

## Interface
- WIDTH, 8: beat data width in bits.
- DEPTH, 4: FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- ACLK  in  1  single clock, rising edge.
- ARESETn  in  1  reset, asynchronous assert, active-low.
- VALID  in  1  bus beat valid from the transmit stage.
- xDATA  in  WIDTH  bus beat data.
- READY  out  1  bus ready to the transmit stage; registered.
- rx_data  out  WIDTH  head-of-FIFO data to the consumer.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pop request.
- rx_count  out  $clog2(DEPTH+1)  current occupancy.
- proto_err  out  1  sticky protocol-violation flag; see Configuration.

## Operation
- push = VALID & READY. On push, xDATA is written at wr_ptr and wr_ptr increments.
- pop = rx_valid & rx_ready. On pop, rd_ptr increments.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- rx_count: next = count + push - pop. This never exceeds DEPTH and never goes below 0.
- rx_valid = (count != 0), combinational from the count register.
- rx_data = mem[rd_ptr], combinational (FWFT). When count == 0, rx_data is don't-care.
- READY register: next = (count_next != DEPTH), computed with the same-cycle push/pop folded in.
- Occupancy states, decoded from count:
  - EMPTY (0): rx_valid = 0, READY = 1.
  - PARTIAL: rx_valid = 1, READY = 1.
  - FULL (DEPTH): rx_valid = 1, READY = 0.
- Transitions per edge:
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop at count DEPTH-1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without push at count 1.
- Simultaneous push and pop in PARTIAL: count is unchanged and both pointers advance.
- FULL: push is impossible because READY = 0. A pop frees one slot, and READY returns to 1 on the following cycle.
- EMPTY: pop is impossible because rx_valid = 0. There is no bypass; a beat pushed into an empty FIFO is visible one cycle later.
- Memory is not reset. Beat order is strictly preserved.

## Timing
- Reset values: READY = 0, rx_valid = 0, rx_count = 0, proto_err = 0, both pointers = 0.
- First rising edge after ARESETn deasserts: READY goes to 1.
- Assertion of ARESETn mid-operation takes effect immediately:
  - All stored beats are discarded.
  - Outputs return to their reset values asynchronously.
- Bus-to-consumer latency: a beat pushed at edge N gives rx_valid = 1 with that data after edge N.
- Full throughput: with VALID and rx_ready held high, one beat per cycle flows with occupancy steady at 1.
- READY deasserts in the cycle after the edge that fills the FIFO.
  - It never deasserts while a push and a pop coincide at count DEPTH-1, since count_next stays at DEPTH-1.

## Configuration
- RX_PROTOCOL_CHECK_EN defined: the checker is compiled in. A violation is any of the following:
  - VALID was 1 with READY 0 in the previous cycle, and VALID is now 0.
  - VALID was 1 with READY 0 in the previous cycle, and xDATA has changed.
- On a violation, proto_err sets at the next edge and stays 1 until reset.
  - The checker needs registered copies of the previous VALID, READY and xDATA.
- RX_PROTOCOL_CHECK_EN undefined: proto_err is tied to 0 and no checker registers exist.
- FIFO behaviour is identical in both builds.

## Test plan
- Reset release: READY = 0, rx_valid = 0 and rx_count = 0 during reset. READY = 1 after the first edge. No push occurs before that.
- Fill with DEPTH = 4 and rx_ready = 0: send 0x11, 0x22, 0x33, 0x44.
  - rx_count goes 1→4 and READY drops after the 4th beat.
  - A 5th beat 0x55 held on VALID is not accepted.
- Drain from full: assert rx_ready for one cycle.
  - 0x11 is popped, READY returns to 1 the next cycle, and 0x55 is then accepted.
  - Subsequent pops yield 0x22, 0x33, 0x44, 0x55 in order.
- Streaming across wrap: VALID and rx_ready held high for 10 beats 0x00–0x09.
  - Every beat arrives in order, each with one cycle of latency.
  - rx_count stays at 1 and READY never drops.
- Mid-operation reset: pulse ARESETn low with 3 beats stored.
  - rx_valid = 0 and rx_count = 0 immediately.
  - After release, the next beat 0xA5 is the first one popped.
- Checker build: with the FIFO full, drop VALID before READY returns, or change xDATA while stalled.
  - proto_err = 1 after the next edge and stays set.
  - In the non-checker build, proto_err stays 0 for the same stimulus.

Source files
------------

// File: rtl/rx_channel_if.sv
// Bus-side handshake of one AXI channel between the transmit stage (master)
// and the receive stage (slave).
interface rx_channel_if #(
    parameter int WIDTH = 8
);
    logic             VALID;
    logic [WIDTH-1:0] xDATA;
    logic             READY;

    modport master (output VALID, output xDATA, input READY);
    modport slave  (input VALID, input xDATA, output READY);
endinterface

// File: rtl/rx_channel.sv
// Receive stage of one AXI channel: registered READY, DEPTH-entry FWFT FIFO, local consumer port.
// Define RX_PROTOCOL_CHECK_EN to compile in the sticky transmitter handshake checker.
module rx_channel #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    rx_channel_if.slave                bus,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH+1)-1:0] rx_count,
    output logic                       proto_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_e;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             ready_q;
    logic             push;
    logic             pop;
    occ_e             occ;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0)
            occ = OCC_EMPTY;
        else if (count == CW'(DEPTH))
            occ = OCC_FULL;
    end

    assign rx_valid  = (occ != OCC_EMPTY);
    assign rx_data   = mem[rd_ptr];
    assign rx_count  = count;
    assign bus.READY = ready_q;

    assign push       = bus.VALID & ready_q;
    assign pop        = rx_valid & rx_ready;
    assign count_next = count + CW'(push) - CW'(pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count   <= count_next;
            // Same-cycle pop is folded in, so a push+pop at DEPTH-1 keeps READY high.
            ready_q <= (count_next != CW'(DEPTH));
        end
    end

    // NOTE: storage has no reset; occupancy and pointers alone define which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge ACLK) begin
        if (push)
            mem[wr_ptr] <= bus.xDATA;
    end

`ifdef RX_PROTOCOL_CHECK_EN
    logic             prev_valid;
    logic             prev_ready;
    logic [WIDTH-1:0] prev_data;
    logic             err_q;
    logic             violation;

    // A stalled beat must stay asserted with unchanged data until accepted.
    assign violation = prev_valid & ~prev_ready &
                       (~bus.VALID | (bus.xDATA != prev_data));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_data  <= '0;
            err_q      <= 1'b0;
        end else begin
            prev_valid <= bus.VALID;
            prev_ready <= ready_q;
            prev_data  <= bus.xDATA;
            err_q      <= err_q | violation;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_rx_channel.sv
// Scoreboard bench for rx_channel: stimulus queues expected beats, a negedge monitor checks pops.
module tb_rx_channel;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef RX_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready = 1'b0;
    logic [CW-1:0]    rx_count;
    logic             proto_err;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [WIDTH-1:0] exp_q [$];

    rx_channel_if #(.WIDTH(WIDTH)) bus ();

    rx_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .bus       (bus),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a pop happens on the next edge whenever rx_valid & rx_ready.
    always @(negedge clk) begin
        if (rst_n && rx_valid === 1'b1 && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none at %0t", rx_data, $time);
            end else begin
                check("pop_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                pops++;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d);
        int budget = 0;
        bus.VALID = 1'b1;
        bus.xDATA = d;
        while (bus.READY !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        if (budget >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got READY=%b expected 1 at %0t", bus.READY, $time);
        end else begin
            exp_q.push_back(d);
            tick();
        end
        bus.VALID = 1'b0;
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_rx_count", {29'h0, rx_count}, 32'h0);
        check("rst_ready", {31'h0, bus.READY}, 32'h0);
        check("rst_proto_err", {31'h0, proto_err}, 32'h0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int budget;
        bus.VALID = 1'b0;
        bus.xDATA = '0;

        // Reset release
        #3;
        check("reset_ready", {31'h0, bus.READY}, 32'h0);
        check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("reset_rx_count", {29'h0, rx_count}, 32'h0);
        tick();
        rst_n = 1'b1;
        check("release_ready_before_edge", {31'h0, bus.READY}, 32'h0);
        tick();
        check("release_ready_after_edge", {31'h0, bus.READY}, 32'h1);
        check("release_count", {29'h0, rx_count}, 32'h0);

        // Fill to full with the consumer stalled
        for (int i = 0; i < DEPTH; i++) begin
            logic [WIDTH-1:0] d;
            d = WIDTH'(8'h11 * (i + 1));
            send(d);
            check("fill_count", {29'h0, rx_count}, 32'(i + 1));
        end
        check("full_ready", {31'h0, bus.READY}, 32'h0);
        check("full_rx_valid", {31'h0, rx_valid}, 32'h1);
        bus.VALID = 1'b1;
        bus.xDATA = 8'h55;
        tick();
        tick();
        check("full_no_accept_count", {29'h0, rx_count}, 32'h4);
        check("full_no_accept_ready", {31'h0, bus.READY}, 32'h0);
        check("legal_stall_no_err", {31'h0, proto_err}, 32'h0);

        // Single pop from full; READY returns and 0x55 is accepted
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("pop_from_full_count", {29'h0, rx_count}, 32'h3);
        check("ready_back", {31'h0, bus.READY}, 32'h1);
        exp_q.push_back(8'h55);
        tick();
        bus.VALID = 1'b0;
        check("refill_count", {29'h0, rx_count}, 32'h4);
        check("refill_ready", {31'h0, bus.READY}, 32'h0);

        // Drain in order
        rx_ready = 1'b1;
        budget = 0;
        while (rx_count != 0 && budget < 20) begin
            tick();
            budget++;
        end
        rx_ready = 1'b0;
        check("drain_count", {29'h0, rx_count}, 32'h0);
        check("drain_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("drain_ready", {31'h0, bus.READY}, 32'h1);

        // Streaming across the pointer wrap
        rx_ready  = 1'b1;
        bus.VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.xDATA = WIDTH'(i);
            check("stream_ready", {31'h0, bus.READY}, 32'h1);
            exp_q.push_back(WIDTH'(i));
            tick();
            check("stream_count", {29'h0, rx_count}, 32'h1);
        end
        bus.VALID = 1'b0;
        tick();
        rx_ready = 1'b0;
        check("stream_end_count", {29'h0, rx_count}, 32'h0);

        // Mid-operation reset with three beats stored
        send(8'h61);
        send(8'h62);
        send(8'h63);
        check("pre_reset_count", {29'h0, rx_count}, 32'h3);
        reset_pulse();
        check("post_reset_ready", {31'h0, bus.READY}, 32'h1);
        send(8'hA5);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("post_reset_drained", {29'h0, rx_count}, 32'h0);
        check("pop_total", 32'(pops), 32'd16);

        // Protocol check: VALID dropped while stalled
        for (int i = 1; i <= DEPTH; i++) send(WIDTH'(i));
        bus.VALID = 1'b1;
        bus.xDATA = 8'h55;
        tick();
        tick();
        check("stall_no_err", {31'h0, proto_err}, 32'h0);
        bus.VALID = 1'b0;
        tick();
        check("drop_valid_err", {31'h0, proto_err}, {31'h0, EXP_ERR});
        tick();
        tick();
        check("drop_valid_sticky", {31'h0, proto_err}, {31'h0, EXP_ERR});
        reset_pulse();

        // Protocol check: xDATA changed while stalled
        for (int i = 1; i <= DEPTH; i++) send(WIDTH'(i));
        bus.VALID = 1'b1;
        bus.xDATA = 8'h66;
        tick();
        check("hold_data_no_err", {31'h0, proto_err}, 32'h0);
        bus.xDATA = 8'h67;
        tick();
        check("change_data_err", {31'h0, proto_err}, {31'h0, EXP_ERR});
        bus.VALID = 1'b0;
        reset_pulse();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
